// File: rtl/seq_mux_pkg.sv
// Shared types and constants for the seq_mux snapshot/stream block.
package seq_mux_pkg;

    // FSM states: waiting for a load, or delivering beats of a held snapshot.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    // Meaning of the mode input, sampled together with load.
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Width needed to index n channels; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_mux_bank.sv
// Snapshot register file: CHANNELS words captured together, one read port.
module seq_mux_bank
    import seq_mux_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = sel_width(CHANNELS)
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cap_en,
    input  logic [CHANNELS*WIDTH-1:0] cap_data,
    input  logic [SEL_W-1:0]          rd_idx,
    output logic [WIDTH-1:0]          rd_data
);

    logic [WIDTH-1:0] bank_reg [CHANNELS];

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_word
            // Each word is cleared by reset and overwritten only on capture.
            always_ff @(posedge clk) begin
                if (rst) begin
                    bank_reg[gi] <= '0;
                end else if (cap_en) begin
                    bank_reg[gi] <= cap_data[gi*WIDTH +: WIDTH];
                end
            end
        end
    endgenerate

    // Read mux; indices at or beyond CHANNELS read as zero instead of off the end.
    always_comb begin
        rd_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (rd_idx == SEL_W'(k)) begin
                rd_data = bank_reg[k];
            end
        end
    end

endmodule

// File: rtl/seq_mux.sv
// Captures CHANNELS input words on load and streams one (direct) or all (scan)
// of them over a valid/ready interface with fully registered outputs.
module seq_mux
    import seq_mux_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    localparam int SEL_W   = sel_width(CHANNELS)
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic                      load,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_idx,
    output logic                      out_last,
    output logic                      sel_err
);

    state_e           state_reg;
    logic             mode_reg;
    logic [SEL_W-1:0] idx_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_last_reg;
    logic             sel_err_reg;

    logic             hs;
    logic             load_ok;
    logic             sel_oob;
    logic             cap;
    logic [SEL_W-1:0] first_idx;
    logic [WIDTH-1:0] first_data;
    logic [SEL_W-1:0] next_idx;
    logic [WIDTH-1:0] bank_rd_data;

    // Load acceptance, out-of-range detection and first-beat selection.
    always_comb begin
        hs        = out_valid_reg && out_ready;
        load_ok   = load && ((state_reg == IDLE) || (hs && out_last_reg));
        sel_oob   = (mode == MODE_DIRECT) && (32'(sel) >= 32'(CHANNELS));
        cap       = load_ok && !sel_oob;
        first_idx = (mode == MODE_SCAN) ? '0 : sel;
        next_idx  = idx_reg + SEL_W'(1);
        // The bank is not written yet on the capture cycle, so take the first
        // beat straight from in_data.
        first_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (first_idx == SEL_W'(k)) begin
                first_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    seq_mux_bank #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .cap_en   (cap),
        .cap_data (in_data),
        .rd_idx   (next_idx),
        .rd_data  (bank_rd_data)
    );

    // FSM, beat sequencing and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            mode_reg      <= MODE_DIRECT;
            idx_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
            sel_err_reg   <= 1'b0;
        end else begin
            sel_err_reg <= load_ok && sel_oob;
            if (cap) begin
                // A last-beat handshake with load lands here too: no bubble.
                state_reg     <= STREAM;
                mode_reg      <= mode;
                idx_reg       <= first_idx;
                out_valid_reg <= 1'b1;
                out_data_reg  <= first_data;
                out_last_reg  <= (mode == MODE_DIRECT);
            end else if (hs) begin
                if (out_last_reg || (mode_reg != MODE_SCAN)) begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    out_last_reg  <= 1'b0;
                end else begin
                    idx_reg      <= next_idx;
                    out_data_reg <= bank_rd_data;
                    out_last_reg <= (next_idx == SEL_W'(CHANNELS - 1));
                end
            end
        end
    end

    assign busy      = (state_reg == STREAM);
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_idx   = idx_reg;
    assign out_last  = out_last_reg;
    assign sel_err   = sel_err_reg;

endmodule
